// File: rtl/normalizer_core.sv
// Two-pass in-place peak normalizer for 16-bit PCM held one sample per 32-bit word.
// Pass 1 finds the peak magnitude, then pass 2 left-shifts every sample and writes it back.
module normalizer_core #(
  parameter int LEN_W       = 16,
  parameter int MAX_SHIFT   = 15,
  parameter int ADDR_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [3:0]       shift_out,
  output logic [15:0]      peak_out,
  output logic [31:0]      dma_addr,
  output logic             dma_read,
  output logic             dma_write,
  output logic [31:0]      dma_writedata,
  input  logic [31:0]      dma_readdata,
  input  logic             dma_rdy
);

  typedef enum logic [3:0] {
    IDLE, RD1_REQ, RD1_WAIT, CALC, RD2_REQ, RD2_WAIT, WR_REQ, WR_WAIT, DONE
  } state_e;

  state_e             state_q;
  logic [31:0]        base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [16:0]        peak_q;
  logic [3:0]         shift_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         shift_out_q;
  logic [15:0]        peak_out_q;
  logic [31:0]        dma_addr_q;
  logic               dma_read_q;
  logic               dma_write_q;
  logic [31:0]        dma_wdata_q;

  logic [16:0]        mag_d;
  logic [3:0]         shift_d;
  logic [15:0]        scaled_d;
  logic               last_d;
  logic               unused_rdata_hi;

  // |s| needs 17 bits so that -32768 maps to +32768.
  function automatic logic [16:0] magnitude(input logic [15:0] s);
    logic [16:0] sx;
    sx = {s[15], s};
    return s[15] ? (~sx + 17'd1) : sx;
  endfunction

  // Largest k <= MAX_SHIFT with (pk << k) <= 32767; a zero peak keeps unity gain.
  function automatic logic [3:0] calc_shift(input logic [16:0] pk);
    logic [3:0] k_best;
    // NOTE: give every function/comb result a default before any conditional
    // update, otherwise a path that skips the assignment infers a latch.
    k_best = 4'd0;
    if (pk != 17'd0) begin
      for (int k = 1; k <= MAX_SHIFT; k++) begin
        if (({15'd0, pk} << k) <= 32'd32767) k_best = 4'(k);
      end
    end
    return k_best;
  endfunction

  assign mag_d           = magnitude(dma_readdata[15:0]);
  assign shift_d         = calc_shift(peak_q);
  assign scaled_d        = dma_readdata[15:0] << shift_q;
  assign last_d          = (idx_q == len_q - LEN_W'(1));
  assign unused_rdata_hi = ^dma_readdata[31:16];

  // NOTE: all state below is sequential, so it is assigned with <= only; that
  // lets the pulse defaults at the top be overridden later in the same block
  // without ordering hazards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      peak_q      <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_out_q <= '0;
      peak_out_q  <= '0;
      dma_addr_q  <= '0;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;
      dma_wdata_q <= '0;
    end else begin
      done_q      <= 1'b0;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= length;
            idx_q      <= '0;
            peak_q     <= '0;
            busy_q     <= 1'b1;
            dma_addr_q <= base_addr;
            if (length == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              shift_out_q <= '0;
              peak_out_q  <= '0;
            end else begin
              state_q    <= RD1_REQ;
              dma_read_q <= 1'b1;
            end
          end
        end

        RD1_REQ: state_q <= RD1_WAIT;

        RD1_WAIT: begin
          if (dma_rdy) begin
            if (mag_d > peak_q) peak_q <= mag_d;
            if (last_d) begin
              idx_q      <= '0;
              dma_addr_q <= base_q;
              state_q    <= CALC;
            end else begin
              idx_q      <= idx_q + LEN_W'(1);
              dma_addr_q <= dma_addr_q + 32'(ADDR_STRIDE);
              dma_read_q <= 1'b1;
              state_q    <= RD1_REQ;
            end
          end
        end

        CALC: begin
          shift_q <= shift_d;
          if (shift_d == 4'd0) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            shift_out_q <= 4'd0;
            peak_out_q  <= peak_q[15:0];
          end else begin
            dma_read_q <= 1'b1;
            state_q    <= RD2_REQ;
          end
        end

        RD2_REQ: state_q <= RD2_WAIT;

        RD2_WAIT: begin
          if (dma_rdy) begin
            dma_wdata_q <= {{16{scaled_d[15]}}, scaled_d};
            dma_write_q <= 1'b1;
            state_q     <= WR_REQ;
          end
        end

        WR_REQ: state_q <= WR_WAIT;

        WR_WAIT: begin
          if (dma_rdy) begin
            if (last_d) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              shift_out_q <= shift_q;
              peak_out_q  <= peak_q[15:0];
            end else begin
              idx_q      <= idx_q + LEN_W'(1);
              dma_addr_q <= dma_addr_q + 32'(ADDR_STRIDE);
              dma_read_q <= 1'b1;
              state_q    <= RD2_REQ;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign shift_out     = shift_out_q;
  assign peak_out      = peak_out_q;
  assign dma_addr      = dma_addr_q;
  assign dma_read      = dma_read_q;
  assign dma_write     = dma_write_q;
  assign dma_writedata = dma_wdata_q;

endmodule

// File: tb/tb_normalizer_core.sv
// Directed bench for normalizer_core: a latency-configurable bridge model backed by a
// sparse word memory, a table of hand-computed buffers, and reset / random sequences.
module tb_normalizer_core;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy, done;
  logic [3:0]  shift_out;
  logic [15:0] peak_out;
  logic [31:0] dma_addr;
  logic        dma_read, dma_write;
  logic [31:0] dma_writedata;
  logic [31:0] dma_readdata;
  logic        dma_rdy;

  always #5 clk = ~clk;

  normalizer_core dut (
    .clk           (clk),
    .rst           (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .shift_out     (shift_out),
    .peak_out      (peak_out),
    .dma_addr      (dma_addr),
    .dma_read      (dma_read),
    .dma_write     (dma_write),
    .dma_writedata (dma_writedata),
    .dma_readdata  (dma_readdata),
    .dma_rdy       (dma_rdy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bridge model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          lat_cfg = 1;   // 0 selects random 1..20
  int          viol = 0;
  int          done_cnt = 0;

  task automatic serve_one();
    bit          is_wr;
    logic [31:0] a, d;
    int          lat;
    is_wr = dma_write;
    a     = dma_addr;
    d     = dma_writedata;
    if (dma_read && dma_write) viol++;
    if (is_wr) begin
      wr_addr_log.push_back(a);
      wr_data_log.push_back(d);
    end else begin
      rd_log.push_back(a);
    end
    lat = (lat_cfg == 0) ? int'($urandom_range(20, 1)) : lat_cfg;
    for (int c = 0; c < lat; c++) begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1) return;
      if (dma_read || dma_write) viol++;
      if (dma_addr !== a || (is_wr && dma_writedata !== d)) viol++;
    end
    if (is_wr) mem[a] = d;
    else dma_readdata = mem.exists(a) ? mem[a] : 32'h0;
    dma_rdy = 1'b1;
    @(posedge clk); #1;
    dma_rdy      = 1'b0;
    dma_readdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    dma_rdy      = 1'b0;
    dma_readdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    forever begin
      if (rst_n === 1'b1 && (dma_read || dma_write)) serve_one();
      else begin @(posedge clk); #1; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- job runner ----------------
  logic [15:0] smp_q[$];

  function automatic logic [31:0] scaled(input logic [15:0] s, input logic [3:0] sh);
    logic signed [15:0] sv;
    logic [15:0]        ns;
    sv = s;
    ns = 16'(sv <<< sh);
    return {{16{ns[15]}}, ns};
  endfunction

  task automatic load_and_clear(input logic [31:0] base);
    mem.delete();
    for (int i = 0; i < smp_q.size(); i++) mem[base + 32'(4 * i)] = {16'hBEEF, smp_q[i]};
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    viol = 0;
  endtask

  task automatic run_job(input string tag, input logic [31:0] base, input logic [15:0] exp_peak,
                         input logic [3:0] exp_shift, input int exp_rd, input int exp_wr,
                         input bit mid_start, input bit start_in_done);
    int len;
    int cycles;
    len = smp_q.size();
    load_and_clear(base);
    @(negedge clk);
    done_cnt  = 0;
    base_addr = base;
    length    = 16'(len);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'hDEAD_0000;
    length    = 16'd7;
    check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      if (mid_start) begin
        start = (cycles == 3);
        if (cycles == 3) base_addr = 32'h0000_9000;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, {31'd0, done}, 32'd1);
    if (len == 0) check({tag, " len0_latency_le2"}, {31'd0, cycles <= 2}, 32'd1);
    check({tag, " shift_out"}, {28'd0, shift_out}, {28'd0, exp_shift});
    check({tag, " peak_out"}, {16'd0, peak_out}, {16'd0, exp_peak});
    if (start_in_done) begin
      start     = 1'b1;
      base_addr = 32'h0000_7000;
      length    = 16'd5;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_done"}, {31'd0, busy}, 32'd0);
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " read_count"}, 32'(rd_log.size()), 32'(exp_rd));
    check({tag, " write_count"}, 32'(wr_addr_log.size()), 32'(exp_wr));
    check({tag, " protocol_violations"}, 32'(viol), 32'd0);
    for (int i = 0; i < rd_log.size() && i < exp_rd; i++)
      check($sformatf("%s rd_addr[%0d]", tag, i), rd_log[i], base + 32'(4 * (i % len)));
    for (int i = 0; i < wr_addr_log.size() && i < exp_wr; i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), wr_addr_log[i], base + 32'(4 * i));
      check($sformatf("%s wr_data[%0d]", tag, i), wr_data_log[i], scaled(smp_q[i], exp_shift));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]      base;
    int               len;
    logic [3:0][15:0] smp;   // smp[0] is sample 0
    logic [15:0]      peak;
    logic [3:0]       shift;
    int               n_rd;
    int               n_wr;
    int               lat;
    bit               mid_start;
    bit               start_in_done;
  } vec_t;

  vec_t tbl[11];

  task automatic load_vec(input vec_t v);
    smp_q.delete();
    for (int i = 0; i < v.len; i++) smp_q.push_back(v.smp[i]);
    lat_cfg = v.lat;
  endtask

  initial begin : main
    int nr, nw, cycles;

    tbl[0]  = '{32'h0000_1000, 3, {16'h0000, 16'h0040, 16'hFF00, 16'h0100}, 16'h0100, 4'd6,  6, 3, 3, 1'b0, 1'b0};
    tbl[1]  = '{32'h0000_2000, 2, {16'h0000, 16'h0000, 16'h0001, 16'h8000}, 16'h8000, 4'd0,  2, 0, 2, 1'b0, 1'b0};
    tbl[2]  = '{32'h0000_3000, 4, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 4'd0,  4, 0, 1, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_4000, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 4'd0,  0, 0, 1, 1'b0, 1'b0};
    tbl[4]  = '{32'h0000_5000, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 16'h0001, 4'd14, 2, 1, 1, 1'b0, 1'b1};
    tbl[5]  = '{32'h0000_6000, 2, {16'h0000, 16'h0000, 16'h8001, 16'h7FFF}, 16'h7FFF, 4'd0,  2, 0, 4, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_7000, 1, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h0001, 4'd14, 2, 1, 2, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_8000, 1, {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h4000, 4'd0,  1, 0, 1, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_9000, 1, {16'h0000, 16'h0000, 16'h0000, 16'h3FFF}, 16'h3FFF, 4'd1,  2, 1, 1, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_A000, 2, {16'h0000, 16'h0000, 16'hFFF8, 16'h0010}, 16'h0010, 4'd10, 4, 2, 2, 1'b0, 1'b0};
    tbl[10] = '{32'hFFFF_FFFC, 2, {16'h0000, 16'h0000, 16'hFFFE, 16'h0002}, 16'h0002, 4'd13, 4, 2, 3, 1'b0, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 32'h0;
    length    = 16'h0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dma_read", {31'd0, dma_read}, 32'd0);
    check("reset dma_write", {31'd0, dma_write}, 32'd0);
    check("reset dma_addr", dma_addr, 32'd0);
    check("reset dma_writedata", dma_writedata, 32'd0);
    check("reset shift_out", {28'd0, shift_out}, 32'd0);
    check("reset peak_out", {16'd0, peak_out}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      load_vec(tbl[v]);
      run_job($sformatf("vec%0d", v), tbl[v].base, tbl[v].peak, tbl[v].shift,
              tbl[v].n_rd, tbl[v].n_wr, tbl[v].mid_start, tbl[v].start_in_done);
    end

    // Reset one cycle after the second write of pass 2 completes.
    load_vec(tbl[0]);
    load_and_clear(tbl[0].base);
    @(negedge clk);
    done_cnt  = 0;
    base_addr = tbl[0].base;
    length    = 16'd3;
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (wr_addr_log.size() < 2 && cycles < BUDGET) begin @(negedge clk); cycles++; end
    while (dma_rdy !== 1'b1 && cycles < BUDGET) begin @(negedge clk); cycles++; end
    check("rst_mid reached second write ack", {31'd0, dma_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid done", {31'd0, done}, 32'd0);
    check("rst_mid dma_read", {31'd0, dma_read}, 32'd0);
    check("rst_mid dma_write", {31'd0, dma_write}, 32'd0);
    nr = rd_log.size();
    nw = wr_addr_log.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid no further reads", 32'(rd_log.size()), 32'(nr));
    check("rst_mid no further writes", 32'(wr_addr_log.size()), 32'(nw));
    check("rst_mid no done", 32'(done_cnt), 32'd0);
    check("rst_mid idle busy", {31'd0, busy}, 32'd0);
    run_job("after_reset", tbl[0].base, 16'h0100, 4'd6, 6, 3, 1'b0, 1'b0);

    // 64 random samples with peak magnitude 0x0123 and random bridge latency.
    smp_q.delete();
    for (int i = 0; i < 64; i++) smp_q.push_back(16'($signed($urandom_range(582, 0)) - 291));
    smp_q[17] = 16'h0123;
    smp_q[40] = 16'hFEDD;
    lat_cfg   = 0;
    run_job("random64", 32'h0002_0000, 16'h0123, 4'd6, 128, 64, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      check($sformatf("random64 mem[%0d]", i), mem[32'h0002_0000 + 32'(4 * i)], scaled(smp_q[i], 4'd6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
